// File: rtl/eth_rx_pkg.sv
// Shared types and helpers for the Ethernet receive frame writer.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  localparam int unsigned FRAME_LEN_W = 11;

  // Number of filled byte lanes (0..4) to a RAM byteenable, lane 0 = bits 7:0
  function automatic logic [3:0] lane_mask(input logic [2:0] filled);
    case (filled)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd3:    lane_mask = 4'b0111;
      3'd4:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/eth_rx_byte_packer.sv
// Little-endian byte-to-word packer. Presents a completed word combinationally
// in the cycle its last byte (lane 3, or a flushing EOP byte) is accepted.
module eth_rx_byte_packer
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  input  logic        clear_i,
  input  logic        flush_i,
  output logic [31:0] word_o,
  output logic [3:0]  be_o,
  output logic        word_valid_o
);

  logic [23:0] part_q;
  logic [1:0]  fill_q;
  logic [1:0]  lane;
  logic [31:0] merged;

  // Merge the incoming byte into the partial word; clear restarts at lane 0
  always_comb begin
    lane   = clear_i ? 2'd0 : fill_q;
    merged = {8'h00, (clear_i ? 24'h000000 : part_q)};
    merged[{lane, 3'b000} +: 8] = data_i;
    word_valid_o = valid_i && ((lane == 2'd3) || flush_i);
    word_o       = merged;
    be_o         = lane_mask({1'b0, lane} + 3'd1);
  end

  // Hold partial lanes; emptied whenever a word is handed out so unfilled lanes read 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      part_q <= '0;
      fill_q <= '0;
    end else if (valid_i) begin
      if (word_valid_o) begin
        part_q <= '0;
        fill_q <= '0;
      end else begin
        part_q <= merged[23:0];
        fill_q <= lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/eth_rx_frame_writer.sv
// Ethernet RX frame writer: packs MAC bytes into 32-bit words, writes each
// frame into a fixed RAM slot and posts (slot, length) completions.
// Optional build macro RX_CRC_STRIP_EN: reported length excludes the 4-byte
// FCS and frames shorter than 5 bytes are dropped.
module eth_rx_frame_writer
  import eth_rx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'd48000,
  parameter int unsigned SLOT_WORDS = 384,
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned SLOT_W     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_sop,
  input  logic                   rx_eop,
  input  logic                   rx_err,
  output logic [15:0]            mem_address,
  output logic [3:0]             mem_byteenable,
  output logic                   mem_chipselect,
  output logic                   mem_write,
  output logic [31:0]            mem_writedata,
  output logic                   mem_clken,
  output logic                   frame_valid,
  output logic [SLOT_W-1:0]      frame_slot,
  output logic [FRAME_LEN_W-1:0] frame_len,
  input  logic                   slot_release,
  input  logic [SLOT_W-1:0]      slot_release_idx,
  output logic [NUM_SLOTS-1:0]   slot_busy,
  output logic [15:0]            drop_cnt
);

  localparam int unsigned WIDX_W = $clog2(SLOT_WORDS + 1);
  localparam logic [FRAME_LEN_W-1:0] LEN_MAX = '1;

  rx_state_e               state_q;
  logic [SLOT_W-1:0]       next_slot_q, cur_slot_q;
  logic [FRAME_LEN_W-1:0]  byte_cnt_q;
  logic [WIDX_W-1:0]       word_idx_q;
  logic                    oversize_q;
  logic [NUM_SLOTS-1:0]    busy_q;
  logic [15:0]             drop_q;

  logic                    mem_write_q;
  logic [15:0]             mem_address_q;
  logic [3:0]              mem_be_q;
  logic [31:0]             mem_wdata_q;
  logic                    frame_valid_q;
  logic [SLOT_W-1:0]       frame_slot_q;
  logic [FRAME_LEN_W-1:0]  frame_len_q;

  // control
  logic                    abort, start_req, start_ok, accept;
  logic [NUM_SLOTS-1:0]    busy_view;

  // packer
  logic [31:0]             pk_word;
  logic [3:0]              pk_be;
  logic                    pk_word_valid;

  // datapath
  logic [SLOT_W-1:0]       eff_slot;
  logic [FRAME_LEN_W-1:0]  eff_bc, bc_next, len_out;
  logic [WIDX_W-1:0]       eff_widx;
  logic                    eff_ov, ov_next, room, wr_go;
  logic [15:0]             wr_addr;
  logic                    eop_now, too_short, frame_bad, good_done, bad_done;
  logic                    alloc_fail_eop, drop_end;
  logic [1:0]              drop_amt;
  logic [16:0]             drop_sum;
  logic [NUM_SLOTS-1:0]    rel_mask, abort_mask, set_mask, bad_mask, busy_d;

  // Frame start / abort decisions; an abort frees its slot before the new allocation looks
  always_comb begin
    abort     = (state_q == RECV) && rx_valid && rx_sop;
    start_req = (state_q != DROP) && rx_valid && rx_sop;
    busy_view = busy_q;
    if (abort) busy_view[cur_slot_q] = 1'b0;
    start_ok  = start_req && !busy_view[next_slot_q];
    accept    = start_ok || ((state_q == RECV) && rx_valid && !rx_sop);
  end

  eth_rx_byte_packer u_packer (
    .clk          (clk),
    .rst          (reset),
    .data_i       (rx_data),
    .valid_i      (accept),
    .clear_i      (start_ok),
    .flush_i      (rx_eop),
    .word_o       (pk_word),
    .be_o         (pk_be),
    .word_valid_o (pk_word_valid)
  );

  // Per-byte datapath: effective frame context (fresh on start), write gating, completion
  always_comb begin
    eff_slot  = start_ok ? next_slot_q : cur_slot_q;
    eff_bc    = start_ok ? '0 : byte_cnt_q;
    eff_widx  = start_ok ? '0 : word_idx_q;
    eff_ov    = start_ok ? 1'b0 : oversize_q;
    bc_next   = (eff_bc == LEN_MAX) ? eff_bc : eff_bc + FRAME_LEN_W'(1);
    room      = (eff_widx != WIDX_W'(SLOT_WORDS));
    wr_go     = accept && pk_word_valid && room;
    ov_next   = eff_ov || (accept && pk_word_valid && !room);
    wr_addr   = BASE_ADDR + 16'(eff_slot) * 16'(SLOT_WORDS) + 16'(eff_widx);
    eop_now   = accept && rx_eop;
`ifdef RX_CRC_STRIP_EN
    len_out   = bc_next - FRAME_LEN_W'(4);
    too_short = (bc_next < FRAME_LEN_W'(5));
`else
    len_out   = bc_next;
    too_short = 1'b0;
`endif
    frame_bad = rx_err || ov_next || too_short;
    good_done = eop_now && !frame_bad;
    bad_done  = eop_now && frame_bad;

    alloc_fail_eop = start_req && !start_ok && rx_eop;
    drop_end       = (state_q == DROP) && rx_valid && rx_eop;
    drop_amt = 2'(abort) + 2'(bad_done) + 2'(alloc_fail_eop) + 2'(drop_end);
    drop_sum = {1'b0, drop_q} + 17'(drop_amt);

    rel_mask   = '0;
    abort_mask = '0;
    set_mask   = '0;
    bad_mask   = '0;
    if (slot_release) rel_mask[slot_release_idx] = 1'b1;
    if (abort)        abort_mask[cur_slot_q]     = 1'b1;
    if (start_ok)     set_mask[next_slot_q]      = 1'b1;
    if (bad_done)     bad_mask[eff_slot]         = 1'b1;
    // Release can only free a slot allocation already saw as busy, so it never races a set
    busy_d = ((busy_q & ~rel_mask & ~abort_mask) | set_mask) & ~bad_mask;
  end

  // FSM, frame context, slot bitmap, counters and registered RAM/completion outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      next_slot_q   <= '0;
      cur_slot_q    <= '0;
      byte_cnt_q    <= '0;
      word_idx_q    <= '0;
      oversize_q    <= 1'b0;
      busy_q        <= '0;
      drop_q        <= '0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_slot_q  <= '0;
      frame_len_q   <= '0;
    end else begin
      case (state_q)
        IDLE, RECV: begin
          if (start_req && !start_ok) state_q <= rx_eop ? IDLE : DROP;
          else if (eop_now)           state_q <= IDLE;
          else if (start_ok)          state_q <= RECV;
        end
        DROP:    if (drop_end) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (start_ok) begin
        cur_slot_q  <= next_slot_q;
        next_slot_q <= next_slot_q + SLOT_W'(1);
      end
      if (accept) begin
        byte_cnt_q <= bc_next;
        oversize_q <= ov_next;
        word_idx_q <= wr_go ? eff_widx + WIDX_W'(1) : eff_widx;
      end

      busy_q <= busy_d;
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

      mem_write_q <= wr_go;
      if (wr_go) begin
        mem_address_q <= wr_addr;
        mem_be_q      <= pk_be;
        mem_wdata_q   <= pk_word;
      end
      frame_valid_q <= good_done;
      if (good_done) begin
        frame_slot_q <= eff_slot;
        frame_len_q  <= len_out;
      end
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_byteenable = mem_be_q;
  assign mem_chipselect = mem_write_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_wdata_q;
  assign mem_clken      = 1'b1;
  assign frame_valid    = frame_valid_q;
  assign frame_slot     = frame_slot_q;
  assign frame_len      = frame_len_q;
  assign slot_busy      = busy_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Self-checking bench for eth_rx_frame_writer: table of frames plus
// hand-written abort / release / reset sequences, scoreboard on RAM writes
// and completion records.
module tb_eth_rx_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sop, rx_eop, rx_err;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic        frame_valid;
  logic [1:0]  frame_slot;
  logic [10:0] frame_len;
  logic        slot_release;
  logic [1:0]  slot_release_idx;
  logic [3:0]  slot_busy;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  eth_rx_frame_writer #(
    .BASE_ADDR  (16'd48000),
    .SLOT_WORDS (384),
    .NUM_SLOTS  (4),
    .SLOT_W     (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_sop           (rx_sop),
    .rx_eop           (rx_eop),
    .rx_err           (rx_err),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .frame_valid      (frame_valid),
    .frame_slot       (frame_slot),
    .frame_len        (frame_len),
    .slot_release     (slot_release),
    .slot_release_idx (slot_release_idx),
    .slot_busy        (slot_busy),
    .drop_cnt         (drop_cnt)
  );

  typedef struct {
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wexp_t;

  typedef struct {
    logic [1:0]  slot;
    logic [10:0] flen;
  } fexp_t;

  typedef struct {
    int flen;
    int seed;
    bit err;
    int rel;   // slot released just before the frame, -1 none
    int slot;  // slot the frame should land in, -1 refused at allocation
  } vec_t;

  wexp_t wq[$];
  fexp_t fq[$];
  vec_t  vecs[10];

  int nchk = 0;
  int nerr = 0;
  logic [3:0]  model_busy;
  logic [15:0] model_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] exp_len(input int len);
`ifdef RX_CRC_STRIP_EN
    return 11'(len - 4);
`else
    return 11'(len);
`endif
  endfunction

  function automatic bit len_ok(input int len);
`ifdef RX_CRC_STRIP_EN
    return (len <= 1536) && (len >= 5);
`else
    return (len <= 1536);
`endif
  endfunction

  // Scoreboard: every RAM write and completion pulse is matched against the queues
  always @(negedge clk) begin : monitor
    wexp_t we;
    fexp_t fe;
    if (!reset) begin
      if (mem_write || mem_chipselect)
        chk("cs_eq_write", 64'(mem_chipselect), 64'(mem_write));
      if (mem_write) begin
        chk("write_in_pool", 64'(mem_address >= 16'd48000 && mem_address < 16'd49536), 64'd1);
        if (wq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_write: addr %0d data %h be %b, none expected",
                   mem_address, mem_writedata, mem_byteenable);
        end else begin
          we = wq.pop_front();
          chk("wr_addr", 64'(mem_address), 64'(we.a));
          chk("wr_be",   64'(mem_byteenable), 64'(we.be));
          chk("wr_data", 64'(mem_writedata), 64'(we.d));
        end
      end
      if (frame_valid) begin
        chk("fv_with_write", 64'(mem_write), 64'd1);
        if (fq.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_frame_valid: slot %0d len %0d, none expected",
                   frame_slot, frame_len);
        end else begin
          fe = fq.pop_front();
          chk("frame_slot", 64'(frame_slot), 64'(fe.slot));
          chk("frame_len",  64'(frame_len),  64'(fe.flen));
        end
      end
    end
  end

  task automatic drive_frame(input int len, input int seed, input bit err, input bit eop_en,
                             input int slot, input int rel_now);
    int nw;
    bit good;
    good = (slot >= 0) && !err && eop_en && len_ok(len);
    if (slot >= 0) begin
      nw = eop_en ? (len + 3) / 4 : len / 4;
      if (nw > 384) nw = 384;
      for (int w = 0; w < nw; w++) begin
        wexp_t e;
        e.a  = 16'(48000 + slot * 384 + w);
        e.d  = '0;
        e.be = '0;
        for (int l = 0; l < 4; l++) begin
          if (w * 4 + l < len) begin
            e.d[l*8 +: 8] = 8'(seed + w * 4 + l);
            e.be[l]       = 1'b1;
          end
        end
        wq.push_back(e);
      end
      if (good) fq.push_back('{slot: 2'(slot), flen: exp_len(len)});
    end
    for (int i = 0; i < len; i++) begin
      rx_valid         = 1'b1;
      rx_data          = 8'(seed + i);
      rx_sop           = (i == 0);
      rx_eop           = eop_en && (i == len - 1);
      rx_err           = err && (i == len - 1);
      slot_release     = (i == 0) && (rel_now >= 0);
      slot_release_idx = (rel_now >= 0) ? 2'(rel_now) : 2'd0;
      @(posedge clk); #1;
    end
    rx_valid     = 1'b0;
    rx_sop       = 1'b0;
    rx_eop       = 1'b0;
    rx_err       = 1'b0;
    slot_release = 1'b0;
  endtask

  task automatic release_slot(input int idx);
    slot_release     = 1'b1;
    slot_release_idx = 2'(idx);
    @(posedge clk); #1;
    slot_release     = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_writes_done"}, 64'(wq.size()), 64'd0);
    chk({tag, "_frames_done"}, 64'(fq.size()), 64'd0);
    chk({tag, "_busy"}, 64'(slot_busy), 64'(model_busy));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(model_drop));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{64,   'h00, 1'b0, -1,  0};  // 0x00..0x3F into empty pool
    vecs[1] = '{5,    'h00, 1'b0, -1,  1};  // partial tail word
    vecs[2] = '{1,    'hA5, 1'b0, -1,  2};  // single-byte frame
    vecs[3] = '{7,    'h10, 1'b0, -1,  3};  // fills the pool
    vecs[4] = '{20,   'h30, 1'b0, -1, -1};  // no free slot
    vecs[5] = '{12,   'h50, 1'b0,  0,  0};  // next_slot wrapped to 0
    vecs[6] = '{9,    'h70, 1'b1,  1,  1};  // rx_err on eop
    vecs[7] = '{1600, 'h11, 1'b0,  2,  2};  // oversize
    vecs[8] = '{1536, 'h22, 1'b0,  3,  3};  // exactly one full slot
    vecs[9] = '{1537, 'h33, 1'b0,  0,  0};  // one byte past the slot

    reset = 1'b1;
    rx_data = '0; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
    slot_release = 1'b0; slot_release_idx = '0;
    model_busy = '0;
    model_drop = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_write",   64'(mem_write), 64'd0);
    chk("rst_chipselect",  64'(mem_chipselect), 64'd0);
    chk("rst_clken",       64'(mem_clken), 64'd1);
    chk("rst_address",     64'(mem_address), 64'd0);
    chk("rst_byteenable",  64'(mem_byteenable), 64'd0);
    chk("rst_writedata",   64'(mem_writedata), 64'd0);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_len",   64'(frame_len), 64'd0);
    chk("rst_slot_busy",   64'(slot_busy), 64'd0);
    chk("rst_drop_cnt",    64'(drop_cnt), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      if (vecs[k].rel >= 0) begin
        release_slot(vecs[k].rel);
        model_busy[vecs[k].rel] = 1'b0;
      end
      drive_frame(vecs[k].flen, vecs[k].seed, vecs[k].err, 1'b1, vecs[k].slot, -1);
      if (vecs[k].slot < 0)
        model_drop++;
      else if (!vecs[k].err && len_ok(vecs[k].flen))
        model_busy[vecs[k].slot] = 1'b1;
      else
        model_drop++;
      settle_check($sformatf("vec%0d", k));
    end

    // SOP after 10 bytes: first frame aborted in slot 1, second completes in slot 2
    drive_frame(10, 'h60, 1'b0, 1'b0, 1, -1);
    drive_frame(8,  'h80, 1'b0, 1'b1, 2, -1);
    model_drop++;
    model_busy[2] = 1'b1;
    settle_check("abort");

    // Releasing a slot that is already free changes nothing
    release_slot(0);
    settle_check("rel_free");

    // Release of slot 3 in the SOP cycle: allocation still sees it busy
    drive_frame(6, 'hC0, 1'b0, 1'b1, -1, 3);
    model_drop++;
    model_busy[3] = 1'b0;
    settle_check("rel_alloc");

    // Reset while a word write is on the bus
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'('hD0 + i);
      rx_sop   = (i == 0);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    chk("pre_reset_write", 64'(mem_write), 64'd1);
    chk("pre_reset_addr",  64'(mem_address), 64'd49152);
    chk("pre_reset_data",  64'(mem_writedata), 64'hD3D2D1D0);
    reset = 1'b1;
    #1;
    chk("mid_reset_write",       64'(mem_write), 64'd0);
    chk("mid_reset_chipselect",  64'(mem_chipselect), 64'd0);
    chk("mid_reset_busy",        64'(slot_busy), 64'd0);
    chk("mid_reset_drop",        64'(drop_cnt), 64'd0);
    chk("mid_reset_clken",       64'(mem_clken), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_busy = '0;
    model_drop = '0;
    @(posedge clk); #1;
    drive_frame(6, 'h20, 1'b0, 1'b1, 0, -1);
    model_busy[0] = 1'b1;
    settle_check("post_reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
